// File: rtl/spi_regbank_bridge_if.sv
// spi_regbank_bridge_if: byte-level SPI link between the SPI byte engine and the register bridge
//   spi_cs_i    chip select, active-low, already synchronous
//   rx_valid_i  one-cycle pulse, rx_byte_i valid
//   rx_byte_i   byte received from the controller
//   tx_byte_o   byte returned on the next transfer
interface spi_regbank_bridge_if;
   logic       spi_cs_i;
   logic       rx_valid_i;
   logic [7:0] rx_byte_i;
   logic [7:0] tx_byte_o;
   modport master (output spi_cs_i, rx_valid_i, rx_byte_i, input tx_byte_o);
   modport slave (input spi_cs_i, rx_valid_i, rx_byte_i, output tx_byte_o);
endinterface

// File: rtl/spi_regbank_bridge.sv
// spi_regbank_bridge: decodes SPI instruction/address/data frames into a bank of control and status words
//   sys_clock_i, rst_i  clock and synchronous active-high reset
//   bus                 SPI byte link (chip select, rx byte pulse, tx byte)
//   rw_regs_o           writable words, word k at [k*DW +: DW]
//   ro_regs_i           read-only status words, same packing
//   wr_strobe_o         one-cycle pulse per written word
//   err_o               one-cycle pulse on a protocol error
module spi_regbank_bridge #(
   parameter int ADDR_BYTES = 3,
   parameter int DATA_BYTES = 4,
   parameter int NUM_RW     = 1,
   parameter int NUM_RO     = 3
) (
   input  logic                           sys_clock_i,
   input  logic                           rst_i,
   spi_regbank_bridge_if.slave            bus,
   output logic [NUM_RW*8*DATA_BYTES-1:0] rw_regs_o,
   input  logic [NUM_RO*8*DATA_BYTES-1:0] ro_regs_i,
   output logic [NUM_RW-1:0]              wr_strobe_o,
   output logic                           err_o
);
   localparam int AW = 8*ADDR_BYTES;
   localparam int DW = 8*DATA_BYTES;
   localparam int NW = NUM_RW + NUM_RO;
   localparam int CW = $clog2((ADDR_BYTES > DATA_BYTES ? ADDR_BYTES : DATA_BYTES) + 1);
   typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, IGNORE} state_t;
   state_t               state_q, state_d;
   logic                 cs_q, valid_q;
   logic [7:0]           byte_q;
   logic                 wr_q, wr_d, burst_q, burst_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [AW-1:0]        addr_q, addr_d, addr_sh, addr_inc, rd_addr;
   logic [DW-1:0]        wdata_q, wdata_d, shift_q, shift_d, word_sh, rd_word;
   logic [7:0]           tx_q, tx_d;
   logic [NUM_RW*DW-1:0] rw_q, rw_d;
   logic [NUM_RW-1:0]    stb_q, stb_d;
   logic                 err_q, err_d;
   logic [NW*DW-1:0]     all_words;
   assign all_words = {ro_regs_i, rw_q};
   assign addr_sh   = (addr_q << 8) | AW'(byte_q);
   assign addr_inc  = addr_q + AW'(1);
   assign word_sh   = (wdata_q << 8) | DW'(byte_q);
   // the word to snapshot is the freshly assembled address on entry, the next one during a burst
   assign rd_addr   = state_q == ADDR ? addr_sh : addr_inc;
   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NW; k++)
         if (rd_addr == AW'(k)) rd_word = all_words[k*DW +: DW];
   end
   always_comb begin
      state_d = state_q;
      wr_d    = wr_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      rw_d    = rw_q;
      stb_d   = '0;
      err_d   = 1'b0;
      if (cs_q) begin
         state_d = IDLE;
         tx_d    = '0;
         cnt_d   = '0;
         wdata_d = '0;
      end else if (valid_q) begin
         case (state_q)
            IDLE: begin
               // valid opcodes are 0x01/0x02 with optional burst bit 7
               if (byte_q[6:2] == 5'd0 && ^byte_q[1:0]) begin
                  state_d = ADDR;
                  wr_d    = byte_q[0];
                  burst_d = byte_q[7];
                  cnt_d   = '0;
                  addr_d  = '0;
               end else begin
                  state_d = IGNORE;
                  err_d   = 1'b1;
               end
            end
            ADDR: begin
               addr_d = addr_sh;
               cnt_d  = cnt_q + CW'(1);
               if (cnt_q == CW'(ADDR_BYTES-1)) begin
                  cnt_d = '0;
                  if (wr_q && addr_sh < AW'(NUM_RW)) state_d = WDATA;
                  else if (!wr_q && addr_sh < AW'(NW)) begin
                     state_d = RDATA;
                     tx_d    = rd_word[DW-1 -: 8];
                     shift_d = rd_word << 8;
                  end else begin
                     state_d = IGNORE;
                     err_d   = 1'b1;
                  end
               end
            end
            WDATA: begin
               wdata_d = word_sh;
               cnt_d   = cnt_q + CW'(1);
               if (cnt_q == CW'(DATA_BYTES-1)) begin
                  cnt_d = '0;
                  for (int k = 0; k < NUM_RW; k++)
                     if (addr_q == AW'(k)) begin
                        rw_d[k*DW +: DW] = word_sh;
                        stb_d[k]         = 1'b1;
                     end
                  if (!burst_q) state_d = IGNORE;
                  else begin
                     addr_d = addr_inc;
                     if (addr_inc >= AW'(NUM_RW)) begin
                        state_d = IGNORE;
                        err_d   = 1'b1;
                     end
                  end
               end
            end
            RDATA: begin
               cnt_d   = cnt_q + CW'(1);
               tx_d    = shift_q[DW-1 -: 8];
               shift_d = shift_q << 8;
               if (cnt_q == CW'(DATA_BYTES-1)) begin
                  cnt_d = '0;
                  tx_d  = '0;
                  if (!burst_q) state_d = IGNORE;
                  else begin
                     addr_d = addr_inc;
                     if (addr_inc < AW'(NW)) begin
                        tx_d    = rd_word[DW-1 -: 8];
                        shift_d = rd_word << 8;
                     end else begin
                        state_d = IGNORE;
                        err_d   = 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end
   // byte-link inputs are registered first so chip select and data are seen in the same cycle
   always_ff @(posedge sys_clock_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cs_q    <= 1'b1;
         valid_q <= 1'b0;
         byte_q  <= '0;
         wr_q    <= 1'b0;
         burst_q <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         shift_q <= '0;
         tx_q    <= '0;
         rw_q    <= '0;
         stb_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cs_q    <= bus.spi_cs_i;
         valid_q <= bus.rx_valid_i;
         byte_q  <= bus.rx_byte_i;
         wr_q    <= wr_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         rw_q    <= rw_d;
         stb_q   <= stb_d;
         err_q   <= err_d;
      end
   end
   assign bus.tx_byte_o = tx_q;
   assign rw_regs_o     = rw_q;
   assign wr_strobe_o   = stb_q;
   assign err_o         = err_q;
endmodule

// File: tb/tb_spi_regbank_bridge.sv
// tb_spi_regbank_bridge: table vectors, corner sequences and random frames against a frame-level model
module tb_spi_regbank_bridge;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] rw_regs;
   logic [95:0] ro_regs;
   logic [0:0]  stb;
   logic        err;
   always #5 clk = ~clk;
   spi_regbank_bridge_if bus();
   spi_regbank_bridge dut (
      .sys_clock_i(clk), .rst_i(rst), .bus(bus), .rw_regs_o(rw_regs),
      .ro_regs_i(ro_regs), .wr_strobe_o(stb), .err_o(err)
   );
   typedef struct {
      int           n;
      logic [191:0] b;
      logic [191:0] m;
      logic [95:0]  ro;
      logic [31:0]  rw;
      int           err;
      int           stb;
   } vec_t;
   vec_t        tv[12];
   int          total = 0, bad = 0;
   int          err_cnt = 0, stb_cnt = 0;
   logic [7:0]  fb[$];
   logic [7:0]  got[64];
   logic [7:0]  em[64];
   int          exp_err, exp_stb;
   logic [31:0] m_rw;
   logic [7:0]  mb;
   always @(negedge clk) begin
      if (err) err_cnt++;
      if (stb[0]) stb_cnt++;
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic send_byte(input logic [7:0] b, output logic [7:0] miso);
      miso = bus.tx_byte_o;
      bus.rx_valid_i = 1'b1;
      bus.rx_byte_i  = b;
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
      @(negedge clk);
   endtask
   task automatic open_cs();
      err_cnt = 0;
      stb_cnt = 0;
      bus.spi_cs_i = 1'b0;
      repeat (2) @(negedge clk);
   endtask
   task automatic close_cs();
      bus.spi_cs_i = 1'b1;
      repeat (3) @(negedge clk);
   endtask
   task automatic run_frame();
      open_cs();
      foreach (fb[i]) send_byte(fb[i], got[i]);
      close_cs();
   endtask
   task automatic compare(input string nm, input logic [31:0] exp_rw);
      foreach (fb[i]) chk($sformatf("%s miso[%0d]", nm, i), 32'(got[i]), 32'(em[i]));
      chk({nm, " err"}, 32'(err_cnt), 32'(exp_err));
      chk({nm, " stb"}, 32'(stb_cnt), 32'(exp_stb));
      chk({nm, " rw"}, rw_regs, exp_rw);
   endtask
   // whole-frame model: words written, MISO byte per position, error count
   task automatic model_frame();
      logic [23:0] a;
      logic [31:0] wv;
      logic        bu, wr;
      int          n;
      n = fb.size();
      for (int i = 0; i < 64; i++) em[i] = 8'h00;
      exp_err = 0;
      exp_stb = 0;
      if (n == 0) return;
      if (!(fb[0] == 8'h01 || fb[0] == 8'h02 || fb[0] == 8'h81 || fb[0] == 8'h82)) begin
         exp_err = 1;
         return;
      end
      if (n < 4) return;
      a  = {fb[1], fb[2], fb[3]};
      bu = fb[0][7];
      wr = fb[0][0];
      if (wr) begin
         if (a >= 1) begin
            exp_err = 1;
            return;
         end
         for (int w = 0; 7 + 4*w < n; w++) begin
            m_rw = {fb[4+4*w], fb[5+4*w], fb[6+4*w], fb[7+4*w]};
            exp_stb++;
            if (!bu) break;
            a++;
            if (a >= 1) begin
               exp_err = 1;
               break;
            end
         end
      end else begin
         for (int k = 0; 3 + 4*k < n; k++) begin
            if (k > 0 && !bu) break;
            if (a >= 4) begin
               exp_err = 1;
               break;
            end
            wv = (a == 0) ? m_rw : ro_regs[32*(int'(a)-1) +: 32];
            for (int c = 0; c < 4; c++)
               if (4 + 4*k + c < n) em[4+4*k+c] = wv[31-8*c -: 8];
            a++;
         end
      end
   endtask
   initial begin
      logic [7:0]  ins;
      logic [23:0] ad;
      int          n;
      bus.spi_cs_i   = 1'b1;
      bus.rx_valid_i = 1'b0;
      bus.rx_byte_i  = 8'h00;
      ro_regs        = '0;
      tv[0]  = '{8,  192'h01000000DEADBEEF, 192'h0, 96'h0, 32'hDEADBEEF, 0, 1};
      tv[1]  = '{9,  192'h020000020000000000, 192'h000000001234567800,
                 96'h00000000_12345678_00000000, 32'hDEADBEEF, 0, 0};
      tv[2]  = '{8,  192'h01000000CAFEF00D, 192'h0, 96'h0, 32'hCAFEF00D, 0, 1};
      tv[3]  = '{21, 192'h82000000_00000000_00000000_00000000_00000000_00,
                 192'h00000000_CAFEF00D_11111111_22222222_33333333_00,
                 96'h33333333_22222222_11111111, 32'hCAFEF00D, 1, 0};
      tv[4]  = '{5,  192'h5500000011, 192'h0, 96'h33333333_22222222_11111111, 32'hCAFEF00D, 1, 0};
      tv[5]  = '{8,  192'h01000001AABBCCDD, 192'h0, 96'h33333333_22222222_11111111, 32'hCAFEF00D, 1, 0};
      tv[6]  = '{12, 192'h81000000_00000042_55667788, 192'h0, 96'h33333333_22222222_11111111, 32'h00000042, 1, 1};
      tv[7]  = '{9,  192'h820000030000000000, 192'h000000003333333300,
                 96'h33333333_22222222_11111111, 32'h00000042, 1, 0};
      tv[8]  = '{5,  192'h0200000400, 192'h0, 96'h33333333_22222222_11111111, 32'h00000042, 1, 0};
      tv[9]  = '{10, 192'h01000000112233445566, 192'h0, 96'h33333333_22222222_11111111, 32'h11223344, 0, 1};
      tv[10] = '{4,  192'h02FFFFFF, 192'h0, 96'h33333333_22222222_11111111, 32'h11223344, 1, 0};
      tv[11] = '{8,  192'h81FFFFFF01020304, 192'h0, 96'h33333333_22222222_11111111, 32'h11223344, 1, 0};
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset rw", rw_regs, 32'h0);
      chk("reset tx", 32'(bus.tx_byte_o), 32'h0);
      chk("reset stb", 32'(stb), 32'h0);
      chk("reset err", 32'(err), 32'h0);
      for (int v = 0; v < 12; v++) begin
         ro_regs = tv[v].ro;
         fb = {};
         for (int j = 0; j < tv[v].n; j++) begin
            fb.push_back(tv[v].b[8*(tv[v].n-1-j) +: 8]);
            em[j] = tv[v].m[8*(tv[v].n-1-j) +: 8];
         end
         exp_err = tv[v].err;
         exp_stb = tv[v].stb;
         run_frame();
         compare($sformatf("vec%0d", v), tv[v].rw);
      end
      // write latency: word and strobe appear together one edge after the sampling edge
      open_cs();
      fb = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hB2, 8'hC3};
      foreach (fb[i]) send_byte(fb[i], mb);
      bus.rx_valid_i = 1'b1;
      bus.rx_byte_i  = 8'hD4;
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
      chk("lat rw early", rw_regs, 32'h11223344);
      chk("lat stb early", 32'(stb), 32'h0);
      @(negedge clk);
      chk("lat rw", rw_regs, 32'hA1B2C3D4);
      chk("lat stb", 32'(stb), 32'h1);
      @(negedge clk);
      chk("lat stb end", 32'(stb), 32'h0);
      close_cs();
      // abort mid-word leaves no trace, following frame writes normally
      fb = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAB, 8'hCD};
      run_frame();
      chk("abort rw", rw_regs, 32'hA1B2C3D4);
      chk("abort stb", 32'(stb_cnt), 32'h0);
      chk("abort err", 32'(err_cnt), 32'h0);
      fb = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h42};
      run_frame();
      chk("post abort rw", rw_regs, 32'h00000042);
      chk("post abort stb", 32'(stb_cnt), 32'h1);
      // chip select release wins over a coincident final byte
      open_cs();
      fb = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC};
      foreach (fb[i]) send_byte(fb[i], mb);
      bus.spi_cs_i   = 1'b1;
      bus.rx_valid_i = 1'b1;
      bus.rx_byte_i  = 8'hDD;
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("cs prio rw", rw_regs, 32'h00000042);
      chk("cs prio stb", 32'(stb_cnt), 32'h0);
      // state and tx byte hold while idle inside a read
      ro_regs = {$urandom, $urandom, $urandom};
      open_cs();
      fb = '{8'h02, 8'h00, 8'h00, 8'h01};
      foreach (fb[i]) send_byte(fb[i], mb);
      repeat (20) @(negedge clk);
      chk("hold tx", 32'(bus.tx_byte_o), 32'(ro_regs[31:24]));
      send_byte(8'h00, mb);
      send_byte(8'h00, mb);
      chk("hold next", 32'(mb), 32'(ro_regs[23:16]));
      close_cs();
      // reset mid-frame
      open_cs();
      fb = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
      foreach (fb[i]) send_byte(fb[i], mb);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("midrst rw", rw_regs, 32'h0);
      chk("midrst tx", 32'(bus.tx_byte_o), 32'h0);
      close_cs();
      fb = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h99, 8'h88, 8'h77, 8'h66};
      run_frame();
      chk("midrst after", rw_regs, 32'h99887766);
      m_rw = 32'h99887766;
      for (int r = 0; r < 150; r++) begin
         ro_regs = {$urandom, $urandom, $urandom};
         case ($urandom_range(0, 9))
            0, 4:    ins = 8'h01;
            1, 5:    ins = 8'h02;
            2, 6:    ins = 8'h81;
            3, 7:    ins = 8'h82;
            default: ins = 8'($urandom);
         endcase
         ad = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 5));
         n  = $urandom_range(1, 22);
         fb = {ins, ad[23:16], ad[15:8], ad[7:0]};
         while (fb.size() < n) fb.push_back(8'($urandom));
         while (fb.size() > n) void'(fb.pop_back());
         model_frame();
         run_frame();
         compare($sformatf("rnd%0d", r), m_rw);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/spi_regbank_bridge.md
# spi_regbank_bridge

Parametrised SPI-to-register-bank bridge. It consumes the byte stream from the byte-level SPI interface and decodes instruction, address and data frames. It serves a bank of writable control words and read-only status words, and adds burst (auto-increment) access, address range checking, frame abort on chip-select release and write strobes. It sits between the SPI byte interface and one or more cores, for example the 6502 decoder.

## Interface

Parameters:
- ADDR_BYTES, 3, address bytes per frame; address width AW = 8*ADDR_BYTES.
- DATA_BYTES, 4, bytes per word; word width DW = 8*DATA_BYTES.
- NUM_RW, 1, writable words at addresses 0..NUM_RW-1.
- NUM_RO, 3, read-only words at addresses NUM_RW..NUM_RW+NUM_RO-1.

Ports:
- sys_clock_i  in  1  system clock; all logic on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- spi_cs_i  in  1  chip select, active-low, already synchronous to sys_clock_i.
- rx_valid_i  in  1  one-cycle pulse; rx_byte_i is valid.
- rx_byte_i  in  8  byte received from the controller.
- tx_byte_o  out  8  byte for the next transfer; registered.
- rw_regs_o  out  NUM_RW*DW  writable words; word k is at bits [k*DW +: DW].
- ro_regs_i  in  NUM_RO*DW  status words from the cores; same packing.
- wr_strobe_o  out  NUM_RW  one-cycle pulse on bit k when word k is written.
- err_o  out  1  one-cycle pulse on a protocol error.

## Operation

- Instructions:
  - 0x01 single write, 0x02 single read.
  - 0x81 burst write, 0x82 burst read.
  - Any other value is invalid.
- Frame format: instruction byte, then ADDR_BYTES address bytes (MSB first), then data bytes (MSB first).
- FSM states: IDLE, ADDR, WDATA, RDATA, IGNORE.
- IDLE, on rx_valid_i:
  - Valid instruction: latch it, clear the byte counter, go to ADDR.
  - Invalid instruction: pulse err_o, go to IGNORE.
- ADDR:
  - Shift rx_byte_i into the address register.
  - After ADDR_BYTES bytes, range-check the full AW-bit address.
  - Write instruction and address < NUM_RW: go to WDATA.
  - Read instruction and address < NUM_RW+NUM_RO: snapshot the addressed word into the shift register, drive its MSB byte on tx_byte_o, go to RDATA.
  - Otherwise (write to a read-only or unmapped address, or read of an unmapped address): pulse err_o, go to IGNORE.
- WDATA:
  - Assemble DATA_BYTES bytes.
  - On the final byte, write the word to rw_regs_o[addr] and pulse wr_strobe_o[addr].
  - Single write: go to IGNORE; extra bytes are discarded with no error.
  - Burst write: increment addr. If the new addr ≥ NUM_RW, pulse err_o and go to IGNORE; otherwise stay in WDATA.
- RDATA:
  - Each rx_valid_i (dummy byte from the controller) advances tx_byte_o to the next byte of the snapshot.
  - After DATA_BYTES bytes, single read: tx_byte_o = 0x00, go to IGNORE.
  - After DATA_BYTES bytes, burst read: increment addr. If in range, snapshot the next word and drive its MSB byte. If out of range, tx_byte_o = 0x00, pulse err_o, go to IGNORE.
- Snapshot: ro_regs_i and rw words are sampled once per word at load time, so a multi-byte read is always coherent.
- IGNORE: all bytes are ignored; tx_byte_o = 0x00.
- spi_cs_i high, in any state:
  - Next state is IDLE and tx_byte_o = 0x00.
  - A partially assembled write word is discarded.
  - spi_cs_i high takes priority over a simultaneous rx_valid_i.
- Address arithmetic is AW bits and wraps modulo 2^AW. The wrapped value is always range-checked.

## Timing

- Reset, effective at the first clock edge with rst_i high:
  - State IDLE.
  - rw_regs_o = 0, tx_byte_o = 0x00.
  - wr_strobe_o = 0, err_o = 0.
  - Counters and the address register = 0.
- Reset mid-frame aborts the frame; a partial write is discarded.
- Notation: edge N is the clock edge sampling rx_valid_i.
- tx_byte_o is updated at edge N+1. The byte interface loads it for the next transfer, so read data appears on the byte following the last address byte.
- Write latency: the rw_regs_o update and the wr_strobe_o pulse happen at edge N+1 of the final data byte, in the same cycle.
- err_o pulses at edge N+1 of the offending byte, and only once per frame.
- rx_valid_i pulses are at least 2 cycles apart. Back-to-back pulses are not supported.
- With no rx_valid_i and spi_cs_i low, the state holds indefinitely.

## Test plan

Parameters are at their defaults.

- Reset: assert rst_i with the bus idle -> rw_regs_o = 0, tx_byte_o = 0x00, wr_strobe_o = 0, err_o = 0.
- Single write: CS low, bytes 01 00 00 00 DE AD BE EF -> rw_regs_o = 0xDEADBEEF one cycle after byte EF, wr_strobe_o[0] pulses once, err_o stays 0.
- Single read: ro word 1 = 0x12345678, bytes 02 00 00 02 followed by 5 dummies -> MISO bytes 12 34 56 78 00.
- Burst read: rw = 0xCAFEF00D, ro = {0x11111111, 0x22222222, 0x33333333}, bytes 82 00 00 00 followed by 17 dummies:
  - Bytes 1-16 return CA FE F0 0D 11 11 11 11 22 22 22 22 33 33 33 33.
  - Byte 17 returns 00.
  - err_o pulses once after the 16th dummy.
- Abort: 01 00 00 00 AB CD, then CS high, then a full write of 0x00000042 -> the abort leaves no change and no strobe; the second frame writes 0x00000042.
- Errors:
  - Instruction 0x55 -> one err_o pulse; subsequent bytes ignored with tx 00.
  - 01 00 00 01 (write to a read-only address) -> one err_o pulse; rw_regs_o unchanged; no wr_strobe_o.
